// File: rtl/neosd_pkg.sv
// Shared definitions for the neosd Wishbone arbiter: bus widths, arbiter
// state encoding and the default strobe timeout.
package neosd_pkg;

    localparam int unsigned WB_ADR_W        = 32;
    localparam int unsigned WB_DAT_W        = 32;
    localparam int unsigned WB_SEL_W        = 4;
    localparam int unsigned TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    // Counter width able to hold TIMEOUT_CYCLES; at least one bit so a
    // disabled timeout still elaborates cleanly.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/neosd_wb_timeout.sv
// Stalled-strobe watchdog: counts owned cycles where the strobe reaches the
// slave without a response, fires once at TIMEOUT_CYCLES, then holds the
// strobe off until the owner drops its own strobe.
module neosd_wb_timeout
    import neosd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic active_i,   // arbiter is in an OWNn state
    input  logic stb_i,      // owner's raw strobe
    input  logic ack_i,
    input  logic err_i,
    output logic block_o,    // suppress the strobe towards the slave
    output logic fire_o      // timeout pulse
);

    localparam int unsigned   CW      = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] cnt_q;
    logic          blk_q;
    logic          resp;
    logic          stall;

    // A slave response in the limit cycle wins over the timeout.
    assign resp    = ack_i | err_i;
    assign fire_o  = (TIMEOUT_CYCLES != 0) && active_i && stb_i && !blk_q &&
                     !resp && (cnt_q == LIMIT);
    assign block_o = blk_q | fire_o;
    assign stall   = active_i && stb_i && !block_o && !resp;

    // Saturating stall counter and sticky strobe block.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            blk_q <= 1'b0;
        end else begin
            if (!stall)
                cnt_q <= '0;
            else if (cnt_q != CNT_MAX)
                cnt_q <= cnt_q + 1'b1;
            blk_q <= active_i && stb_i && block_o;
        end
    end

endmodule

// File: rtl/neosd_wb_arbiter.sv
// Two-requester round-robin Wishbone arbiter in front of the neosd slave.
// Ownership lasts while the owner's cyc is high; bus signals are steered
// combinationally, so grant latency is one cycle and an abort is immediate.
module neosd_wb_arbiter
    import neosd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    input  logic                m0_we_i,
    input  logic [WB_ADR_W-1:0] m0_adr_i,
    input  logic [WB_DAT_W-1:0] m0_dat_i,
    input  logic [WB_SEL_W-1:0] m0_sel_i,
    output logic                m0_ack_o,
    output logic                m0_err_o,
    output logic [WB_DAT_W-1:0] m0_dat_o,
    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    input  logic                m1_we_i,
    input  logic [WB_ADR_W-1:0] m1_adr_i,
    input  logic [WB_DAT_W-1:0] m1_dat_i,
    input  logic [WB_SEL_W-1:0] m1_sel_i,
    output logic                m1_ack_o,
    output logic                m1_err_o,
    output logic [WB_DAT_W-1:0] m1_dat_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [WB_ADR_W-1:0] s_adr_o,
    output logic [WB_DAT_W-1:0] s_dat_o,
    output logic [WB_SEL_W-1:0] s_sel_o,
    input  logic                s_ack_i,
    input  logic                s_err_i,
    input  logic [WB_DAT_W-1:0] s_dat_i,
    output logic [1:0]          grant_o,
    output logic                timeout_o
);

    arb_state_e state_q, state_d;
    logic       last_q;      // requester served most recently
    logic       req0, req1;
    logic       active, owner_stb;
    logic       tmo_block, tmo_fire;

    assign req0      = m0_cyc_i & m0_stb_i;
    assign req1      = m1_cyc_i & m1_stb_i;
    assign active    = (state_q != ST_IDLE);
    assign owner_stb = (state_q == ST_OWN0) ? m0_stb_i :
                       (state_q == ST_OWN1) ? m1_stb_i : 1'b0;
    assign grant_o   = {state_q == ST_OWN1, state_q == ST_OWN0};
    assign timeout_o = tmo_fire;

    // Next owner: arbitrate only from IDLE, release when owner drops cyc.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req0 && req1)
                    state_d = last_q ? ST_OWN0 : ST_OWN1;
                else if (req0)
                    state_d = ST_OWN0;
                else if (req1)
                    state_d = ST_OWN1;
            end
            ST_OWN0: if (!m0_cyc_i) state_d = ST_IDLE;
            ST_OWN1: if (!m1_cyc_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and round-robin pointer (m0 wins the first tie).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && state_d != ST_IDLE)
                last_q <= (state_d == ST_OWN1);
        end
    end

    neosd_wb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .active_i(active),
        .stb_i   (owner_stb),
        .ack_i   (s_ack_i),
        .err_i   (s_err_i),
        .block_o (tmo_block),
        .fire_o  (tmo_fire)
    );

    // Bus steering: owner's signals to the slave, slave response to owner.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_dat_o = '0;
        case (state_q)
            ST_OWN0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i & ~tmo_block;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | tmo_fire;
                m0_dat_o = s_dat_i;
            end
            ST_OWN1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i & ~tmo_block;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | tmo_fire;
                m1_dat_o = s_dat_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_neosd_wb_arbiter.sv
// Bench for neosd_wb_arbiter: two instances (timeout 8 and timeout 0) share
// one stimulus; a behavioural model predicts every output each cycle, and
// directed literal checks pin the key timings.
module tb_neosd_wb_arbiter;

    localparam int T_A = 8;
    localparam int T_B = 0;
    localparam int OW  = 160;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_din;
    logic [3:0]  m0_sel, m1_sel;
    logic        s_ack, s_err;

    logic        m0_ack [2], m0_err [2], m1_ack [2], m1_err [2];
    logic        s_cyc [2], s_stb [2], s_we [2], tmo [2];
    logic [31:0] m0_dout [2], m1_dout [2], s_adr [2], s_dout [2];
    logic [3:0]  s_sel [2];
    logic [1:0]  grant [2];

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        neosd_wb_arbiter #(.TIMEOUT_CYCLES(k == 0 ? T_A : T_B)) u_dut (
            .clk_i(clk), .rst_i(rst),
            .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
            .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel),
            .m0_ack_o(m0_ack[k]), .m0_err_o(m0_err[k]), .m0_dat_o(m0_dout[k]),
            .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
            .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel),
            .m1_ack_o(m1_ack[k]), .m1_err_o(m1_err[k]), .m1_dat_o(m1_dout[k]),
            .s_cyc_o(s_cyc[k]), .s_stb_o(s_stb[k]), .s_we_o(s_we[k]),
            .s_adr_o(s_adr[k]), .s_dat_o(s_dout[k]), .s_sel_o(s_sel[k]),
            .s_ack_i(s_ack), .s_err_i(s_err), .s_dat_i(s_din),
            .grant_o(grant[k]), .timeout_o(tmo[k])
        );
    end

    function automatic logic [OW-1:0] pack(
        input logic [1:0] g, input logic t, c, s, w,
        input logic [31:0] a, d, input logic [3:0] sl,
        input logic a0, e0, input logic [31:0] d0,
        input logic a1, e1, input logic [31:0] d1);
        return {18'd0, g, t, c, s, w, a, d, sl, a0, e0, d0, a1, e1, d1};
    endfunction

    function automatic logic [OW-1:0] act_of(input int k);
        return pack(grant[k], tmo[k], s_cyc[k], s_stb[k], s_we[k], s_adr[k],
                    s_dout[k], s_sel[k], m0_ack[k], m0_err[k], m0_dout[k],
                    m1_ack[k], m1_err[k], m1_dout[k]);
    endfunction

    task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner: -1 idle, else requester index; stall = completed stalled strobes.
    int          own_m [2]   = '{-1, -1};
    int          last_m [2]  = '{1, 1};
    int          stall_m [2] = '{0, 0};
    bit          blk_m [2]   = '{1'b0, 1'b0};
    int          own_n [2], last_n [2], stall_n [2];
    bit          blk_n [2];
    logic [OW-1:0] exp_v [2];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            int   tk, o;
            logic rcyc, rstb, resp, fire, eff;
            tk   = (k == 0) ? T_A : T_B;
            o    = own_m[k];
            resp = s_ack | s_err;
            rcyc = 1'b0; rstb = 1'b0; fire = 1'b0; eff = 1'b0;
            exp_v[k]   = '0;
            own_n[k]   = -1;
            last_n[k]  = last_m[k];
            stall_n[k] = 0;
            blk_n[k]   = 1'b0;
            if (rst) begin
                last_n[k] = 1;
            end else if (o < 0) begin
                if (m0_cyc && m0_stb && m1_cyc && m1_stb) own_n[k] = (last_m[k] == 0) ? 1 : 0;
                else if (m0_cyc && m0_stb)                 own_n[k] = 0;
                else if (m1_cyc && m1_stb)                 own_n[k] = 1;
                if (own_n[k] >= 0) last_n[k] = own_n[k];
            end else begin
                rcyc = (o == 0) ? m0_cyc : m1_cyc;
                rstb = (o == 0) ? m0_stb : m1_stb;
                fire = (tk != 0) && (stall_m[k] == tk) && rstb && !blk_m[k] && !resp;
                eff  = rstb && !blk_m[k] && !fire;
                if (o == 0)
                    exp_v[k] = pack(2'b01, fire, rcyc, eff, m0_we, m0_adr, m0_dat, m0_sel,
                                    s_ack, s_err | fire, s_din, 1'b0, 1'b0, 32'd0);
                else
                    exp_v[k] = pack(2'b10, fire, rcyc, eff, m1_we, m1_adr, m1_dat, m1_sel,
                                    1'b0, 1'b0, 32'd0, s_ack, s_err | fire, s_din);
                stall_n[k] = (eff && !resp && tk != 0) ? stall_m[k] + 1 : 0;
                blk_n[k]   = rstb && (blk_m[k] || fire);
                own_n[k]   = rcyc ? o : -1;
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                own_m[k] <= -1; last_m[k] <= 1; stall_m[k] <= 0; blk_m[k] <= 1'b0;
            end else begin
                own_m[k] <= own_n[k]; last_m[k] <= last_n[k];
                stall_m[k] <= stall_n[k]; blk_m[k] <= blk_n[k];
            end
        end
    end

    // Compare every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("model_t8", act_of(0), exp_v[0]);
                chk("model_t0", act_of(1), exp_v[1]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();   @(posedge clk); #1; endtask
    task automatic settle(); #3; endtask
    task automatic m0_req(input logic c, input logic s); m0_cyc = c; m0_stb = s; endtask
    task automatic m1_req(input logic c, input logic s); m1_cyc = c; m1_stb = s; endtask

    initial begin
        int bad;
        rst = 1'b0;
        m0_req(0, 0); m1_req(0, 0); m0_we = 0; m1_we = 0;
        m0_adr = 0; m0_dat = 0; m1_adr = 0; m1_dat = 0; m0_sel = 0; m1_sel = 0;
        s_ack = 0; s_err = 0; s_din = 0;
        #1 rst = 1'b1;
        #1 chk_en = 1'b1;

        // reset: outputs 0 even with a request pending
        tick; m0_req(1, 1); settle;
        chk("rst_grant", grant[0], 0);
        chk("rst_all_zero", act_of(0), 0);
        tick; tick; m0_req(0, 0); rst = 1'b0;

        // m0 alone reads, ack 3 cycles after strobe
        m0_req(1, 1); m0_adr = 32'h100; m0_sel = 4'hF; settle;
        chk("idle_no_grant", grant[0], 0);
        chk("idle_no_stb", s_stb[0], 0);
        tick; settle;
        chk("r037_grant", grant[0], 2'b01);
        chk("r037_stb", s_stb[0], 1);
        chk("r037_adr", s_adr[0], 32'h100);
        tick; tick;
        tick; s_ack = 1; s_din = 32'hCAFE0001; settle;
        chk("r037_ack", m0_ack[0], 1);
        chk("r037_dat", m0_dout[0], 32'hCAFE0001);
        chk("r037_m1_quiet", {m1_ack[0], m1_err[0], m1_dout[0]}, 0);
        tick; s_ack = 0; s_din = 0; m0_req(0, 0); settle;
        chk("r037_ack_1cyc", m0_ack[0], 0);
        chk("r037_abort", s_cyc[0], 0);
        tick; settle;
        chk("r037_idle", grant[0], 0);

        // simultaneous requests after reset
        rst = 1'b1; tick; rst = 1'b0;
        m0_req(1, 1); m1_req(1, 1); m1_adr = 32'h200; m1_sel = 4'h3;
        tick; s_ack = 1; settle;
        chk("r038_first_m0", grant[0], 2'b01);
        tick; s_ack = 0; m0_req(0, 0); settle;
        chk("r038_m0_tail", grant[0], 2'b01);
        tick; settle;
        chk("r038_gap_idle", grant[0], 0);
        tick; s_ack = 1; settle;
        chk("r038_then_m1", grant[0], 2'b10);
        chk("r038_m1_ack", m1_ack[0], 1);
        tick; s_ack = 0; m1_req(0, 0);
        tick; m0_req(1, 1); m1_req(1, 1); settle;
        chk("r038_idle2", grant[0], 0);
        tick; settle;
        chk("r038_tie2_m0", grant[0], 2'b01);
        tick; m0_req(0, 0); m1_req(0, 0);
        tick;

        // m1 burst with stb gaps, m0 waiting (last served m0 -> m1 wins tie)
        m0_req(1, 1); m1_req(1, 1); m1_we = 1;
        for (int b = 0; b < 4; b++) begin
            tick; m1_stb = 1; s_ack = 1; s_din = 32'(b); settle;
            chk("r039_beat", grant[0], 2'b10);
            chk("r039_m0_wait", m0_ack[0], 0);
            tick; m1_stb = 0; s_ack = 0; settle;
            chk("r039_gap_hold", grant[0], 2'b10);
        end
        tick; m1_cyc = 0; settle;
        chk("r039_release_abort", s_cyc[0], 0);
        tick; settle;
        chk("r039_gap_idle", grant[0], 0);
        tick; s_ack = 1; s_din = 32'h1234; settle;
        chk("r039_m0_after", grant[0], 2'b01);
        chk("r039_m0_dat", m0_dout[0], 32'h1234);
        tick; s_ack = 0; m0_req(0, 0); m1_we = 0;
        tick;

        // timeout: slave silent, T=8
        m0_req(1, 1); m0_we = 1; m0_adr = 32'h300; m0_dat = 32'hDEAD;
        tick;
        for (int i = 1; i <= 8; i++) begin
            settle;
            chk("r040_stall_stb", s_stb[0], 1);
            chk("r040_stall_no_tmo", tmo[0], 0);
            tick;
        end
        settle;
        chk("r040_fire_tmo", tmo[0], 1);
        chk("r040_fire_err", m0_err[0], 1);
        chk("r040_fire_stb", s_stb[0], 0);
        chk("r040_t0_silent", {tmo[1], m0_err[1], s_stb[1]}, 3'b001);
        tick; settle;
        chk("r040_blocked", {s_stb[0], tmo[0], m0_err[0]}, 0);
        tick; m0_stb = 0; settle;
        chk("r040_stb_low", s_stb[0], 0);
        tick; m0_stb = 1; s_ack = 1; settle;
        chk("r040_unblocked", s_stb[0], 1);
        chk("r040_ack", m0_ack[0], 1);
        tick; s_ack = 0; m0_req(0, 0);
        tick;

        // response in the limit cycle wins; ack+err both forwarded
        m0_req(1, 1);
        tick; repeat (8) tick;
        s_ack = 1; s_err = 1; settle;
        chk("r031_no_tmo", tmo[0], 0);
        chk("r030_both", {m0_ack[0], m0_err[0], s_stb[0]}, 3'b111);
        tick; s_ack = 0; s_err = 0; m0_req(0, 0);
        tick;

        // async reset while m1 owns with strobe outstanding
        m1_req(1, 1); m1_adr = 32'h400;
        tick; #1;
        chk("r041_pre", grant[0], 2'b10);
        rst = 1'b1; #1;
        chk("r041_async_zero_t8", act_of(0), 0);
        chk("r041_async_zero_t0", act_of(1), 0);
        tick; tick; rst = 1'b0; m0_req(1, 1); settle;
        chk("r041_release_idle", grant[0], 0);
        tick; settle;
        chk("r041_post_m0", grant[0], 2'b01);
        tick; m0_req(0, 0); m1_req(0, 0);
        tick;

        // T=0: 1000-cycle stall, ack forwarded, never an error
        bad = 0;
        m0_req(1, 1); m0_we = 0;
        tick;
        for (int i = 1; i < 1000; i++) begin
            settle;
            if (tmo[1] || m0_err[1]) bad++;
            tick;
        end
        s_ack = 1; s_din = 32'h5A5A0042; settle;
        chk("r042_no_err_seen", bad, 0);
        chk("r042_ack", {m0_ack[1], m0_err[1], tmo[1]}, 3'b100);
        chk("r042_dat", m0_dout[1], 32'h5A5A0042);
        tick; s_ack = 0; m0_req(0, 0);
        tick; tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
